seq_mult16: RTL and testbench

//  Sequential 16x16 unsigned shift-add multiplier; produces a 32-bit product.

---
 rtl/seq_mult16_pkg.sv | 14 +
 rtl/seq_mult16_add16.sv | 25 ++
 rtl/seq_mult16.sv | 137 +++++++++++++
 tb/tb_seq_mult16.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult16_pkg.sv
// Shared types and sizing for the seq_mult16 sequential multiplier.
package seq_mult16_pkg;

   localparam int WIDTH  = 16;
   localparam int CNT_W  = 4;
   localparam int PROD_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_mult16_add16.sv
// ADD16: 16-bit ripple-carry adder, the single arithmetic element of seq_mult16.
module seq_mult16_add16
   import seq_mult16_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   logic carry;

   // Ripple the carry from bit 0 upward, one full adder per bit.
   always_comb begin
      s     = '0;
      carry = ci;
      for (int i = 0; i < WIDTH; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      co = carry;
   end

endmodule

// File: rtl/seq_mult16.sv
// seq_mult16: 16x16 unsigned shift-add multiplier built around one ADD16.
// One partial-product add per cycle for 16 cycles, then a one-cycle done pulse.
// Optional build macro ZERO_BYPASS_EN: a zero operand skips the iteration and
// completes on the cycle after the start is accepted.
module seq_mult16 #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   import seq_mult16_pkg::*;

   // The only legal width is the one ADD16 is built for.
   generate
      if (WIDTH != seq_mult16_pkg::WIDTH) begin : g_bad_width
         $error("seq_mult16: WIDTH must be 16 to match ADD16");
      end
   endgenerate

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]  addend;
   logic [WIDTH-1:0]  sum;
   logic              carry_out;
   // Partial-product register. The architectural 33rd bit is always zero
   // after a shift, so only the low 32 bits are stored; the adder carry
   // lands in bit 31 and is never lost.
   logic [PROD_W-1:0] p;
   logic [PROD_W-1:0] p_shift;
   logic              accept;
   logic              last_step;
   logic              zero_op;

   assign accept    = start && (state != RUN);
   assign last_step = (state == RUN) && (cnt == '1);

`ifdef ZERO_BYPASS_EN
   assign zero_op = (a == '0) || (b == '0);
`else
   assign zero_op = 1'b0;
`endif

   // Add the multiplicand into the upper half only when the current
   // multiplier bit (p[0]) is set.
   assign addend  = p[0] ? mcand : '0;
   assign p_shift = {carry_out, sum, p[WIDTH-1:1]};

   seq_mult16_add16 u_add16 (
      .a  (p[PROD_W-1:WIDTH]),
      .b  (addend),
      .ci (1'b0),
      .s  (sum),
      .co (carry_out)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: accept in IDLE/DONE, iterate 16 times in RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = zero_op ? DONE : RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (last_step) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode directly from the registered state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Iteration counter and partial-product shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         p   <= '0;
      end else if (accept) begin
         cnt <= '0;
         p   <= {{WIDTH{1'b0}}, b};
      end else if (state == RUN) begin
         cnt <= cnt + 1'b1;
         p   <= p_shift;
      end
   end

   // Multiplicand is captured only on an accepted start.
   always_ff @(posedge clk) begin
      if (accept) begin
         mcand <= a;
      end
   end

   // Result register: updated only when an operation completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         product <= '0;
      end else if (last_step) begin
         product <= p_shift;
      end else if (accept && zero_op) begin
         product <= '0;
      end
   end

endmodule

// File: tb/tb_seq_mult16.sv
// Scoreboard bench for seq_mult16: stimulus pushes expected results, a
// monitor pops and compares on every done pulse.
module tb_seq_mult16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   seq_mult16 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef ZERO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef struct {
      logic [31:0] prod;
      int unsigned due;
      int unsigned run;
      int          id;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          passes = 0;
   int          viol = 0;
   int          op_id = 0;
   int unsigned run_len = 0;
   bit          mon_en = 1'b0;
   logic [31:0] last_prod;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // Monitor: protocol invariants every cycle, scoreboard compare on done.
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy && done) begin
            viol++;
            $display("FAIL busy_and_done: both high at cycle %0d", cyc);
         end
         if (busy && (product !== last_prod)) begin
            viol++;
            $display("FAIL product_during_run: got %h, expected %h", product, last_prod);
         end
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
            end else begin
               mon_e = sb.pop_front();
               check($sformatf("op%0d_product", mon_e.id), product, mon_e.prod);
               check($sformatf("op%0d_done_cycle", mon_e.id), cyc, mon_e.due);
               check($sformatf("op%0d_busy_cycles", mon_e.id), run_len, mon_e.run);
            end
            run_len = 0;
         end else if (busy) begin
            run_len++;
         end else begin
            run_len = 0;
         end
         last_prod = product;
      end
   end

   task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] pe, input bit track);
      exp_t e;
      bit   z;
      a     = av;
      b     = bv;
      start = 1'b1;
      if (track) begin
         z      = BYPASS && ((av == 16'h0) || (bv == 16'h0));
         e.prod = pe;
         e.due  = cyc + (z ? 32'd1 : 32'd17);
         e.run  = z ? 0 : 16;
         e.id   = op_id;
         op_id++;
         sb.push_back(e);
      end
   endtask

   // Returns on the cycle done is high, leaving start low.
   task automatic wait_done(input string nm);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) return;
      end
      checks++;
      $display("FAIL %s_timeout: done not seen in 40 cycles, expected a pulse", nm);
   endtask

   logic [15:0] ta [12] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234, 16'h8000, 16'hFFFF,
                            16'hABCD, 16'h0100, 16'h00FF, 16'hFFFF, 16'h0000, 16'h0003};
   logic [15:0] tb_ [12] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h5678, 16'h0002, 16'h0000,
                             16'h0001, 16'h0100, 16'h00FF, 16'h8000, 16'h0000, 16'h0005};
   logic [31:0] tp [12] = '{32'h0000FFFF, 32'h0000FFFF, 32'h40000000, 32'h06260060,
                            32'h00010000, 32'h00000000, 32'h0000ABCD, 32'h00010000,
                            32'h0000FE01, 32'h7FFF8000, 32'h00000000, 32'h0000000F};

   initial begin
      bit got;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_product", product, 32'd0);
      rst       = 1'b0;
      last_prod = product;
      mon_en    = 1'b1;
      @(negedge clk);

      // Basic product and latency.
      issue(16'd3, 16'd5, 32'h0000000F, 1'b1);
      wait_done("t1");
      @(negedge clk);

      // Carry out of the adder must reach bit 31.
      issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
      wait_done("t2");
      @(negedge clk);

      // Zero multiplicand.
      issue(16'h0000, 16'h1234, 32'h00000000, 1'b1);
      wait_done("t3");
      @(negedge clk);

      // start held high during RUN is ignored; taken again in the DONE cycle.
      issue(16'd2, 16'd4, 32'd8, 1'b1);
      @(negedge clk);
      a   = 16'd7;
      b   = 16'd9;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (got) begin
         issue(16'd7, 16'd9, 32'd63, 1'b1);
         wait_done("t4b");
      end else begin
         checks++;
         $display("FAIL t4a_timeout: done not seen in 40 cycles, expected a pulse");
      end
      @(negedge clk);

      // Reset in the middle of RUN aborts the operation.
      issue(16'd100, 16'd200, 32'd0, 1'b0);
      repeat (8) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("t5_busy_mid_run", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_busy_after_rst", 32'(busy), 32'd0);
      check("t5_done_after_rst", 32'(done), 32'd0);
      check("t5_product_after_rst", product, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      issue(16'd10, 16'd10, 32'd100, 1'b1);
      wait_done("t5");

      // Back-to-back directed vectors, each started in the previous DONE cycle.
      for (int i = 0; i < 12; i++) begin
         issue(ta[i], tb_[i], tp[i], 1'b1);
         wait_done($sformatf("vec%0d", i));
      end
      repeat (3) @(negedge clk);

      check("protocol_violations", viol, 32'd0);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
